// File: rtl/low_freq_period_counter_pkg.sv
// rtl/low_freq_period_counter_pkg.sv - shared state type and default sizing for the low-frequency counter
package low_freq_counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE,
        DONE
    } state_d;

    localparam int DEFAULT_PERIOD_W   = 20;
    localparam int DEFAULT_TIMEOUT_US = 1000000;

endpackage

// File: rtl/low_freq_period_counter_if.sv
// rtl/low_freq_period_counter_if.sv - start/signal inputs and result outputs of the period counter
interface low_freq_period_counter_if
    import low_freq_counter_pkg::*;
#(
    parameter int PERIOD_W = DEFAULT_PERIOD_W
) ();

    logic                start_tick_i;
    logic                sig_i;
    logic                busy_o;
    logic                done_tick_o;
    logic [PERIOD_W-1:0] period_us_o;
    logic                timeout_o;

    modport master (
        output start_tick_i,
        output sig_i,
        input  busy_o,
        input  done_tick_o,
        input  period_us_o,
        input  timeout_o
    );

    modport slave (
        input  start_tick_i,
        input  sig_i,
        output busy_o,
        output done_tick_o,
        output period_us_o,
        output timeout_o
    );

endinterface

// File: rtl/low_freq_period_counter_sync_edge_detector.sv
// rtl/low_freq_period_counter_sync_edge_detector.sv - 2-FF synchroniser with rising-edge tick
module sync_edge_detector (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic rise_tick_o
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= async_i;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign rise_tick_o = r_sync & ~r_hist;

endmodule

// File: rtl/low_freq_period_counter.sv
// rtl/low_freq_period_counter.sv - times one period of a slow input between consecutive rising edges in microseconds
module low_freq_period_counter
    import low_freq_counter_pkg::*;
#(
    parameter int CLK_CYCLES_PER_US = 100,
    parameter int PERIOD_W          = DEFAULT_PERIOD_W,
    parameter int TIMEOUT_US        = DEFAULT_TIMEOUT_US
) (
    input  logic clk_i,
    input  logic reset_i,
    low_freq_period_counter_if.slave bus
);

    localparam int                  PRESC_W    = (CLK_CYCLES_PER_US > 2) ? $clog2(CLK_CYCLES_PER_US) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(CLK_CYCLES_PER_US - 1);
    localparam logic [PERIOD_W-1:0] US_MAX     = '1;
    localparam logic [PERIOD_W-1:0] US_LIMIT   = PERIOD_W'(TIMEOUT_US);

    state_d              r_state;
    state_d              w_next;
    logic                w_edge;
    logic                w_clear;
    logic                w_capture;
    logic                w_cap_timeout;
    logic                w_counting;
    logic [PRESC_W-1:0]  r_presc;
    logic [PERIOD_W-1:0] r_us_cnt;
    logic [PERIOD_W-1:0] r_cap_period;
    logic                r_cap_timeout;
    logic [PERIOD_W-1:0] r_period;
    logic                r_timeout;
    logic                r_done;

    sync_edge_detector u_sync (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .async_i     (bus.sig_i),
        .rise_tick_o (w_edge)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_clear       = 1'b0;
        w_capture     = 1'b0;
        w_cap_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start_tick_i) begin
                    w_clear = 1'b1;
                    w_next  = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (w_edge) begin
                    w_clear = 1'b1;
                    w_next  = MEASURE;
                end else if (r_us_cnt == US_LIMIT) begin
                    w_capture     = 1'b1;
                    w_cap_timeout = 1'b1;
                    w_next        = DONE;
                end
            end
            MEASURE: begin
                if (w_edge) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end else if (r_us_cnt == US_LIMIT) begin
                    w_capture     = 1'b1;
                    w_cap_timeout = 1'b1;
                    w_next        = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_counting = (r_state == WAIT_EDGE) || (r_state == MEASURE);

    // The clearing cycle itself is already one elapsed cycle, so the prescaler restarts at 1
    // and us_cnt at an edge equals floor(cycles since the clear / CLK_CYCLES_PER_US).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_presc  <= '0;
            r_us_cnt <= '0;
        end else if (w_clear) begin
            r_presc  <= PRESC_W'(1);
            r_us_cnt <= '0;
        end else if (w_counting) begin
            if (r_presc == PRESC_LAST) begin
                r_presc <= '0;
                if (r_us_cnt != US_MAX) r_us_cnt <= r_us_cnt + PERIOD_W'(1);
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cap_period  <= '0;
            r_cap_timeout <= 1'b0;
            r_period      <= '0;
            r_timeout     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cap_period  <= r_us_cnt;
                r_cap_timeout <= w_cap_timeout;
            end
            r_done <= (r_state == DONE);
            if (r_state == DONE) begin
                r_period  <= r_cap_period;
                r_timeout <= r_cap_timeout;
            end
        end
    end

    assign bus.busy_o      = (r_state != IDLE);
    assign bus.done_tick_o = r_done;
    assign bus.period_us_o = r_period;
    assign bus.timeout_o   = r_timeout;

endmodule

// File: tb/tb_low_freq_period_counter.sv
// tb/tb_low_freq_period_counter.sv - scoreboard bench for low_freq_period_counter
module tb_low_freq_period_counter;

    localparam int C      = 10;
    localparam int W      = 16;
    localparam int TO_US  = 500;
    localparam int TO_CYC = TO_US * C;

    typedef struct {
        int cyc;
        int period;
        int to;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   done_seen = 0;
    exp_t exp_q[$];
    int   rises[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    low_freq_period_counter_if #(.PERIOD_W(W)) bus ();

    low_freq_period_counter #(
        .CLK_CYCLES_PER_US (C),
        .PERIOD_W          (W),
        .TIMEOUT_US        (TO_US)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit   busy_chk;
        busy_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_chk) begin
                check("busy_after_done", int'(bus.busy_o), 0);
                busy_chk = 1'b0;
            end
            if (bus.done_tick_o) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("period_us", int'(bus.period_us_o), e.period);
                    check("timeout", int'(bus.timeout_o), e.to);
                    busy_chk = 1'b1;
                end
            end
        end
    end

    // Reference: edges are seen 3 cycles after a rise is driven, the start 1 cycle after;
    // the result is the first two edges strictly after the start, under the timeout window.
    task automatic run_case(input int width, input bit init_high, input int dbl_off);
        int   edges[$];
        int   rel_done;
        int   per;
        int   to_flag;
        int   t_begin;
        exp_t e;
        bit   hi;
        foreach (rises[i]) if (rises[i] + 3 > 1) edges.push_back(rises[i] + 3);
        edges.sort();
        if (edges.size() == 0 || edges[0] > 1 + TO_CYC) begin
            rel_done = 1 + TO_CYC + 1;
            per      = TO_US;
            to_flag  = 1;
        end else if (edges.size() < 2 || edges[1] - edges[0] > TO_CYC) begin
            rel_done = edges[0] + TO_CYC + 1;
            per      = TO_US;
            to_flag  = 1;
        end else begin
            rel_done = edges[1] + 1;
            per      = (edges[1] - edges[0]) / C;
            to_flag  = 0;
        end
        t_begin = -12;
        foreach (rises[i]) if (rises[i] - 2 < t_begin) t_begin = rises[i] - 2;
        for (int t = t_begin; t <= rel_done + 3; t++) begin
            @(posedge clk);
            #1;
            if (t == 0) begin
                e.cyc    = cyc + rel_done;
                e.period = per;
                e.to     = to_flag;
                exp_q.push_back(e);
            end
            if (t == 200 && rel_done > 205) check("busy_during", int'(bus.busy_o), 1);
            bus.start_tick_i = (t == 0) || (dbl_off != 0 && t == dbl_off);
            hi = init_high && (t < 3);
            foreach (rises[i]) if (t >= rises[i] && t < rises[i] + width) hi = 1'b1;
            bus.sig_i = hi;
        end
    endtask

    initial begin : stimulus
        int r1;
        int per;
        rst              = 1'b1;
        bus.start_tick_i = 1'b0;
        bus.sig_i        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_done", int'(bus.done_tick_o), 0);
        check("rst_period", int'(bus.period_us_o), 0);
        check("rst_timeout", int'(bus.timeout_o), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1 bus.sig_i = ((t % 20) < 10);
        end
        bus.sig_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_no_done", done_seen, 0);
        check("idle_busy", int'(bus.busy_o), 0);

        rises = '{10, 2010, 4010};   run_case(1000, 1'b0, 0);
        rises = '{20, 1257};         run_case(5, 1'b0, 0);
        rises = '{};                 run_case(4, 1'b0, 0);
        rises = '{10, 1510};         run_case(6, 1'b0, 500);
        rises = '{-2, 40, 840};      run_case(4, 1'b0, 0);
        rises = '{30, 530};          run_case(4, 1'b1, 0);
        rises = '{10, 5010};         run_case(4, 1'b0, 0);
        rises = '{10, 5011};         run_case(4, 1'b0, 0);
        rises = '{4998, 5198};       run_case(4, 1'b0, 0);

        rises = '{};
        @(posedge clk);
        #1 bus.start_tick_i = 1'b1;
        for (int t = 1; t <= 1000; t++) begin
            @(posedge clk);
            #1;
            bus.start_tick_i = 1'b0;
            bus.sig_i        = (t >= 10 && t < 14);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", int'(bus.busy_o), 0);
        check("midrst_done", int'(bus.done_tick_o), 0);
        check("midrst_period", int'(bus.period_us_o), 0);
        check("midrst_timeout", int'(bus.timeout_o), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rises = '{10, 3010};         run_case(8, 1'b0, 0);

        for (int k = 0; k < 8; k++) begin
            r1 = int'($urandom_range(4, 60));
            if ($urandom_range(0, 3) == 0) per = int'($urandom_range(TO_CYC - 5, TO_CYC + 5));
            else                           per = int'($urandom_range(20, 3000));
            rises = '{r1, r1 + per};
            if ($urandom_range(0, 1) == 1) rises.push_back(r1 + 2 * per);
            run_case(int'($urandom_range(1, 8)), 1'b0, 0);
        end

        repeat (10) @(posedge clk);
        #1;
        check("pending_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
